// File: rtl/user_dma_pkg.sv
// Shared types for the DMA completion router: FSM state encoding and tag-table entry.
package user_dma_pkg;

  localparam int OWNER_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DROP  = 2'd2
  } cpl_state_e;

  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
  } tag_entry_t;

endpackage

// File: rtl/user_dma_cpl_router_if.sv
// Request/completion bus of user_dma_cpl_router. The router uses modport slave;
// the DMA engines and user slaves (or a bench) use modport master.
interface user_dma_cpl_router_if #(
  parameter int NUM_SLAVES = 4,
  parameter int TAG_WIDTH  = 8,
  parameter int DATA_WIDTH = 64
);
  localparam int SLV_W = $clog2(NUM_SLAVES);

  logic                  i_req_fire;
  logic [TAG_WIDTH-1:0]  i_req_tag;
  logic [SLV_W-1:0]      i_req_slave;
  logic                  i_cpl_valid;
  logic [TAG_WIDTH-1:0]  i_cpl_tag;
  logic [DATA_WIDTH-1:0] i_cpl_data;
  logic                  i_cpl_last;
  logic                  o_cpl_ready;
  logic [NUM_SLAVES-1:0] o_slave_cpl_valid;
  logic [DATA_WIDTH-1:0] o_slave_cpl_data;
  logic [TAG_WIDTH-1:0]  o_slave_cpl_tag;
  logic                  o_slave_cpl_last;
  logic [NUM_SLAVES-1:0] i_slave_cpl_ready;
  logic [TAG_WIDTH:0]    o_outstanding;
  logic                  o_cpl_err;

  modport slave (
    input  i_req_fire, i_req_tag, i_req_slave,
    input  i_cpl_valid, i_cpl_tag, i_cpl_data, i_cpl_last,
    input  i_slave_cpl_ready,
    output o_cpl_ready, o_slave_cpl_valid, o_slave_cpl_data, o_slave_cpl_tag,
    output o_slave_cpl_last, o_outstanding, o_cpl_err
  );

  modport master (
    output i_req_fire, i_req_tag, i_req_slave,
    output i_cpl_valid, i_cpl_tag, i_cpl_data, i_cpl_last,
    output i_slave_cpl_ready,
    input  o_cpl_ready, o_slave_cpl_valid, o_slave_cpl_data, o_slave_cpl_tag,
    input  o_slave_cpl_last, o_outstanding, o_cpl_err
  );

endinterface

// File: rtl/user_dma_tag_table.sv
// Tag ownership table: one allocation write port, one release port, combinational lookup.
// Allocation overrides a release of the same tag in the same cycle.
module user_dma_tag_table
  import user_dma_pkg::*;
#(
  parameter int TAG_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_alloc_en,
  input  logic [TAG_WIDTH-1:0] i_alloc_tag,
  input  logic [OWNER_W-1:0]   i_alloc_owner,
  input  logic                 i_rel_en,
  input  logic [TAG_WIDTH-1:0] i_rel_tag,
  input  logic [TAG_WIDTH-1:0] i_lkp_tag,
  output tag_entry_t           o_lkp_entry,
  output logic                 o_alloc_hit,
  output logic                 o_rel_hit
);

  localparam int DEPTH = 2 ** TAG_WIDTH;

  tag_entry_t table_r [DEPTH];

  // Table update: release first so a same-tag allocation overrides it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= '0;
      end
    end else begin
      if (i_rel_en) begin
        table_r[i_rel_tag].valid <= 1'b0;
      end
      if (i_alloc_en) begin
        table_r[i_alloc_tag] <= '{valid: 1'b1, owner: i_alloc_owner};
      end
    end
  end

  assign o_lkp_entry = table_r[i_lkp_tag];
  assign o_alloc_hit = table_r[i_alloc_tag].valid;
  assign o_rel_hit   = table_r[i_rel_tag].valid;

endmodule

// File: rtl/user_dma_cpl_router.sv
// Routes DMA read completions to the user slave that owns the tag, through one output stage.
// Define USER_DMA_CPL_TAG_CHECK_EN to discard completions for unallocated tags (DROP state).
module user_dma_cpl_router
  import user_dma_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int TAG_WIDTH  = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  user_dma_cpl_router_if.slave  bus
);

  localparam int SLV_W = $clog2(NUM_SLAVES);
  localparam logic [TAG_WIDTH:0] CNT_MAX = (TAG_WIDTH+1)'(2 ** TAG_WIDTH);

  cpl_state_e            state_r, state_nxt_s;
  tag_entry_t            lkp_entry_s;
  logic [SLV_W-1:0]      burst_owner_r, out_owner_r, route_owner_s;
  logic [TAG_WIDTH-1:0]  burst_tag_r, rel_tag_s, out_tag_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [NUM_SLAVES-1:0] slave_valid_r;
  logic [TAG_WIDTH:0]    cnt_r;
  logic                  out_last_r, err_r;
  logic                  alloc_hit_s, rel_hit_s, slave_ok_s, alloc_ok_s, dup_s, inc_s, dec_s;
  logic                  route_ok_s, tag_ok_s, accept_s, cpl_ready_s;
  logic                  fwd_s, rel_en_s, tag_err_s;

  user_dma_tag_table #(.TAG_WIDTH(TAG_WIDTH)) u_tag_table (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_alloc_en    (alloc_ok_s),
    .i_alloc_tag   (bus.i_req_tag),
    .i_alloc_owner (OWNER_W'(bus.i_req_slave)),
    .i_rel_en      (rel_en_s),
    .i_rel_tag     (rel_tag_s),
    .i_lkp_tag     (bus.i_cpl_tag),
    .o_lkp_entry   (lkp_entry_s),
    .o_alloc_hit   (alloc_hit_s),
    .o_rel_hit     (rel_hit_s)
  );

  assign cpl_ready_s = !(|slave_valid_r) | bus.i_slave_cpl_ready[out_owner_r];
  assign accept_s    = bus.i_cpl_valid & cpl_ready_s;
  assign route_ok_s  = lkp_entry_s.owner < OWNER_W'(NUM_SLAVES);
`ifdef USER_DMA_CPL_TAG_CHECK_EN
  assign tag_ok_s    = lkp_entry_s.valid & route_ok_s;
`else
  assign tag_ok_s    = route_ok_s;
`endif

  // Allocation bookkeeping; a re-allocation racing its own release is not a duplicate
  assign slave_ok_s = {1'b0, bus.i_req_slave} < (SLV_W+1)'(NUM_SLAVES);
  assign alloc_ok_s = bus.i_req_fire & slave_ok_s;
  assign dup_s      = alloc_ok_s & alloc_hit_s & !(rel_en_s & (rel_tag_s == bus.i_req_tag));
  assign inc_s      = alloc_ok_s & !dup_s;
  assign dec_s      = rel_en_s & rel_hit_s;

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !bus.i_cpl_last) begin
`ifdef USER_DMA_CPL_TAG_CHECK_EN
          state_nxt_s = tag_ok_s ? ST_BURST : ST_DROP;
`else
          state_nxt_s = ST_BURST;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (accept_s && bus.i_cpl_last) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
`ifdef USER_DMA_CPL_TAG_CHECK_EN
      ST_DROP: begin
        if (accept_s && bus.i_cpl_last) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
`endif
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: forward/discard decision, routing target and tag release
  always_comb begin
    fwd_s         = 1'b0;
    rel_en_s      = 1'b0;
    tag_err_s     = 1'b0;
    rel_tag_s     = bus.i_cpl_tag;
    route_owner_s = lkp_entry_s.owner[SLV_W-1:0];
    case (state_r)
      ST_IDLE: begin
        if (accept_s && tag_ok_s) begin
          fwd_s    = 1'b1;
          rel_en_s = bus.i_cpl_last;
        end else begin
          tag_err_s = accept_s;
        end
      end
      ST_BURST: begin
        route_owner_s = burst_owner_r;
        rel_tag_s     = burst_tag_r;
        if (accept_s) begin
          fwd_s    = 1'b1;
          rel_en_s = bus.i_cpl_last;
        end else begin
          fwd_s    = 1'b0;
        end
      end
      default: begin
        fwd_s = 1'b0;
      end
    endcase
  end

  // Owner and tag of the completion currently being streamed
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      burst_owner_r <= '0;
      burst_tag_r   <= '0;
    end else if (state_r == ST_IDLE && accept_s) begin
      burst_owner_r <= route_owner_s;
      burst_tag_r   <= bus.i_cpl_tag;
    end
  end

  // Single output stage; holds while the owning slave back-pressures
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slave_valid_r <= '0;
      out_owner_r   <= '0;
      out_data_r    <= '0;
      out_tag_r     <= '0;
      out_last_r    <= 1'b0;
    end else if (cpl_ready_s) begin
      if (fwd_s) begin
        slave_valid_r <= NUM_SLAVES'(1) << route_owner_s;
        out_owner_r   <= route_owner_s;
        out_data_r    <= bus.i_cpl_data;
        out_tag_r     <= bus.i_cpl_tag;
        out_last_r    <= bus.i_cpl_last;
      end else begin
        slave_valid_r <= '0;
      end
    end
  end

  // Saturating outstanding-tag counter and registered error pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      if (inc_s && !dec_s && cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + (TAG_WIDTH+1)'(1);
      end else if (dec_s && !inc_s && cnt_r != '0) begin
        cnt_r <= cnt_r - (TAG_WIDTH+1)'(1);
      end
      err_r <= (bus.i_req_fire & !slave_ok_s) | dup_s | tag_err_s;
    end
  end

  assign bus.o_cpl_ready       = cpl_ready_s;
  assign bus.o_slave_cpl_valid = slave_valid_r;
  assign bus.o_slave_cpl_data  = out_data_r;
  assign bus.o_slave_cpl_tag   = out_tag_r;
  assign bus.o_slave_cpl_last  = out_last_r;
  assign bus.o_outstanding     = cnt_r;
  assign bus.o_cpl_err         = err_r;

endmodule

// File: tb/tb_user_dma_cpl_router.sv
// Directed self-checking bench for user_dma_cpl_router (NUM_SLAVES=5 so slave index 5 is out of range).
module tb_user_dma_cpl_router;

  localparam int NS = 5;
  localparam int TW = 8;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  user_dma_cpl_router_if #(.NUM_SLAVES(NS), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) bus ();

  user_dma_cpl_router #(.NUM_SLAVES(NS), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [7:0] tag, input logic [2:0] slv);
    bus.i_req_fire  = 1'b1;
    bus.i_req_tag   = tag;
    bus.i_req_slave = slv;
    step();
    bus.i_req_fire  = 1'b0;
  endtask

  // Drive one beat, clock it through and check the output stage one cycle later
  task automatic beat(input string nm, input logic [7:0] tag, input logic [63:0] data,
                      input logic last, input logic [4:0] exp_vld);
    bus.i_cpl_valid = 1'b1;
    bus.i_cpl_tag   = tag;
    bus.i_cpl_data  = data;
    bus.i_cpl_last  = last;
    step();
    check_eq({nm, "_vld"}, 64'(bus.o_slave_cpl_valid), 64'(exp_vld));
    if (exp_vld != 5'b0) begin
      check_eq({nm, "_data"}, bus.o_slave_cpl_data, data);
      check_eq({nm, "_last"}, 64'(bus.o_slave_cpl_last), 64'(last));
      check_eq({nm, "_tag"},  64'(bus.o_slave_cpl_tag), 64'(tag));
    end
  endtask

  task automatic cpl_idle();
    bus.i_cpl_valid = 1'b0;
    bus.i_cpl_last  = 1'b0;
  endtask

  initial begin
    bus.i_req_fire        = 1'b0;
    bus.i_req_tag         = 8'h00;
    bus.i_req_slave       = 3'd0;
    bus.i_cpl_valid       = 1'b0;
    bus.i_cpl_tag         = 8'h00;
    bus.i_cpl_data        = 64'h0;
    bus.i_cpl_last        = 1'b0;
    bus.i_slave_cpl_ready = 5'b11111;

    // Reset state
    #12;
    check_eq("rst_vld",   64'(bus.o_slave_cpl_valid), 64'h0);
    check_eq("rst_out",   64'(bus.o_outstanding), 64'h0);
    check_eq("rst_err",   64'(bus.o_cpl_err), 64'h0);
    check_eq("rst_data",  bus.o_slave_cpl_data, 64'h0);
    check_eq("rst_ready", 64'(bus.o_cpl_ready), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Tag 0x05 -> slave 2, four back-to-back beats
    alloc(8'h05, 3'd2);
    check_eq("r20_out1", 64'(bus.o_outstanding), 64'd1);
    check_eq("r20_err",  64'(bus.o_cpl_err), 64'h0);
    for (int b = 0; b < 4; b++) begin
      beat("r20", 8'h05, 64'hA0 + 64'(b), (b == 3), 5'b00100);
    end
    cpl_idle();
    check_eq("r20_out0", 64'(bus.o_outstanding), 64'd0);
    step();
    check_eq("r20_drain", 64'(bus.o_slave_cpl_valid), 64'h0);

    // Tag 0x10 -> slave 1, slave stalls 3 cycles mid-burst
    alloc(8'h10, 3'd1);
    beat("r21_b0", 8'h10, 64'hB0, 1'b0, 5'b00010);
    bus.i_cpl_data        = 64'hB1;
    bus.i_slave_cpl_ready = 5'b11101;
    #1;
    check_eq("r21_rdy_lo", 64'(bus.o_cpl_ready), 64'h0);
    for (int s = 0; s < 3; s++) begin
      step();
      check_eq("r21_hold_vld",  64'(bus.o_slave_cpl_valid), 64'b00010);
      check_eq("r21_hold_data", bus.o_slave_cpl_data, 64'hB0);
      check_eq("r21_hold_rdy",  64'(bus.o_cpl_ready), 64'h0);
    end
    bus.i_slave_cpl_ready = 5'b11111;
    #1;
    check_eq("r21_rdy_hi", 64'(bus.o_cpl_ready), 64'h1);
    beat("r21_b1", 8'h10, 64'hB1, 1'b0, 5'b00010);
    beat("r21_b2", 8'h10, 64'hB2, 1'b0, 5'b00010);
    beat("r21_b3", 8'h10, 64'hB3, 1'b1, 5'b00010);
    cpl_idle();
    check_eq("r21_out0", 64'(bus.o_outstanding), 64'd0);

    // Out-of-range slave index, then duplicate allocation
    alloc(8'h20, 3'd5);
    check_eq("r25_err",  64'(bus.o_cpl_err), 64'h1);
    check_eq("r25_out",  64'(bus.o_outstanding), 64'd0);
    step();
    check_eq("r25_pulse", 64'(bus.o_cpl_err), 64'h0);
    alloc(8'h21, 3'd1);
    alloc(8'h21, 3'd4);
    check_eq("dup_err", 64'(bus.o_cpl_err), 64'h1);
    check_eq("dup_out", 64'(bus.o_outstanding), 64'd1);
    beat("dup_route", 8'h21, 64'hD1, 1'b1, 5'b10000);
    cpl_idle();
    check_eq("dup_out0", 64'(bus.o_outstanding), 64'd0);

    // Same-cycle allocate and release of tag 0x07
    alloc(8'h07, 3'd0);
    bus.i_req_fire  = 1'b1;
    bus.i_req_tag   = 8'h07;
    bus.i_req_slave = 3'd3;
    beat("r22_old", 8'h07, 64'hC7, 1'b1, 5'b00001);
    bus.i_req_fire  = 1'b0;
    cpl_idle();
    check_eq("r22_out", 64'(bus.o_outstanding), 64'd1);
    check_eq("r22_err", 64'(bus.o_cpl_err), 64'h0);
    beat("r22_new", 8'h07, 64'hC8, 1'b1, 5'b01000);
    cpl_idle();
    check_eq("r22_out0", 64'(bus.o_outstanding), 64'd0);

    // Two-beat completion for never-allocated tag 0x33
`ifdef USER_DMA_CPL_TAG_CHECK_EN
    beat("r23_b0", 8'h33, 64'hE0, 1'b0, 5'b00000);
    check_eq("r23_err", 64'(bus.o_cpl_err), 64'h1);
    beat("r23_b1", 8'h33, 64'hE1, 1'b1, 5'b00000);
    check_eq("r23_pulse", 64'(bus.o_cpl_err), 64'h0);
`else
    beat("r23_b0", 8'h33, 64'hE0, 1'b0, 5'b00001);
    check_eq("r23_err", 64'(bus.o_cpl_err), 64'h0);
    beat("r23_b1", 8'h33, 64'hE1, 1'b1, 5'b00001);
`endif
    cpl_idle();
    check_eq("r23_out", 64'(bus.o_outstanding), 64'd0);
    alloc(8'h34, 3'd2);
    beat("r23_next", 8'h34, 64'hE2, 1'b1, 5'b00100);
    cpl_idle();

    // Reset mid-burst with three tags outstanding
    alloc(8'h40, 3'd0);
    alloc(8'h41, 3'd1);
    alloc(8'h42, 3'd2);
    check_eq("r24_out3", 64'(bus.o_outstanding), 64'd3);
    beat("r24_b0", 8'h40, 64'hF0, 1'b0, 5'b00001);
    beat("r24_b1", 8'h40, 64'hF1, 1'b0, 5'b00001);
    #2;
    rst = 1'b1;
    #1;
    check_eq("r24_rst_out",  64'(bus.o_outstanding), 64'd0);
    check_eq("r24_rst_vld",  64'(bus.o_slave_cpl_valid), 64'h0);
    check_eq("r24_rst_data", bus.o_slave_cpl_data, 64'h0);
    check_eq("r24_rst_rdy",  64'(bus.o_cpl_ready), 64'h1);
    cpl_idle();
    @(negedge clk);
    rst = 1'b0;
    alloc(8'h40, 3'd3);
    check_eq("r24_out1", 64'(bus.o_outstanding), 64'd1);
    beat("r24_n0", 8'h40, 64'hF2, 1'b0, 5'b01000);
    beat("r24_n1", 8'h40, 64'hF3, 1'b1, 5'b01000);
    cpl_idle();
    check_eq("r24_out0", 64'(bus.o_outstanding), 64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
